four_phase_rx_endpoint: RTL

- Receiving end of the team's four-phase (return-to-zero) req/ack bundled-data handshake.
- An asynchronous sender in another clock domain drives req_in and data_in.
- This block:
  - synchronizes req_in into its single clock domain;
  - captures data_in and returns ack_out;
  - presents each word to a local consumer through a one-entry valid/taken output register with backpressure.
- It pairs with the sender side of our handshake CDC path.

---
 rtl/four_phase_rx_endpoint_if.sv | 28 ++
 rtl/four_phase_rx_endpoint.sv | 112 +++++++++++
 2 files changed

// File: rtl/four_phase_rx_endpoint_if.sv
// Handshake and consumer bundle for the four-phase receive endpoint.
//   req_in/data_in/ack_out : four-phase req/ack bundled-data link to the sender
//   data_out/dataready/data_taken : one-entry valid/taken path to the consumer
//   stall, xfer_count : status
// The master modport is the environment (sender and consumer). The slave
// modport is the endpoint.
interface four_phase_rx_endpoint_if #(
  parameter int N = 8
);
  logic         req_in;
  logic [N-1:0] data_in;
  logic         ack_out;
  logic [N-1:0] data_out;
  logic         dataready;
  logic         data_taken;
  logic         stall;
  logic [15:0]  xfer_count;

  modport master (
    output req_in, data_in, data_taken,
    input  ack_out, data_out, dataready, stall, xfer_count
  );

  modport slave (
    input  req_in, data_in, data_taken,
    output ack_out, data_out, dataready, stall, xfer_count
  );
endinterface

// File: rtl/four_phase_rx_endpoint.sv
// Receive end of a four-phase (return-to-zero) bundled-data handshake.
// req_in is asynchronous to clk. It passes through a SYNC_STAGES flop
// synchronizer. When the synchronized request is seen in IDLE, data_in is
// captured into a one-entry output register and ack_out is raised. ack_out
// stays high until the request returns to zero.
// Ports:
//   clk     : receive-domain clock, rising edge
//   reset_n : asynchronous active-low reset, released synchronously
//   bus     : slave side of four_phase_rx_endpoint_if (see interface)
// Every output is driven straight from a flop. SYNC_STAGES must be 2..4.
module four_phase_rx_endpoint #(
  parameter int N           = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic                    clk,
  input  logic                    reset_n,
  four_phase_rx_endpoint_if.slave bus
);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    ACK  = 1'b1
  } state_t;

  state_t                 state_r;
  logic [SYNC_STAGES-1:0] sync_r;
  logic                   ack_r;
  logic [N-1:0]           data_r;
  logic                   dataready_r;
  logic                   stall_r;
  logic [15:0]            count_r;

  logic req_s;
  logic slot_free_s;

  assign req_s = sync_r[SYNC_STAGES-1];
  // The slot is free when it is empty, or when the consumer drains it on
  // this same edge. The second case allows a capture and a take to overlap.
  assign slot_free_s = (~dataready_r) | bus.data_taken;

  assign bus.ack_out    = ack_r;
  assign bus.data_out   = data_r;
  assign bus.dataready  = dataready_r;
  assign bus.stall      = stall_r;
  assign bus.xfer_count = count_r;

  // Synchronizer chain, handshake FSM and output register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r     <= IDLE;
      sync_r      <= {SYNC_STAGES{1'b0}};
      ack_r       <= 1'b0;
      data_r      <= {N{1'b0}};
      dataready_r <= 1'b0;
      stall_r     <= 1'b0;
      count_r     <= 16'h0000;
    end else begin
      sync_r <= {sync_r[SYNC_STAGES-2:0], bus.req_in};
      case (state_r)
        IDLE: begin
          if (req_s) begin
            if (slot_free_s) begin
              // data_in has been stable since req_in rose, so sampling it
              // here is safe even though it crosses from another domain.
              data_r      <= bus.data_in;
              dataready_r <= 1'b1;
              ack_r       <= 1'b1;
              stall_r     <= 1'b0;
              count_r     <= count_r + 16'd1;
              state_r     <= ACK;
            end else begin
              // The register is full and not being taken, so it stays
              // untouched. The sender waits with ack low.
              ack_r   <= 1'b0;
              stall_r <= 1'b1;
            end
          end else begin
            ack_r   <= 1'b0;
            stall_r <= 1'b0;
            if (bus.data_taken) begin
              dataready_r <= 1'b0;
            end else begin
              dataready_r <= dataready_r;
            end
          end
        end
        ACK: begin
          stall_r <= 1'b0;
          if (bus.data_taken) begin
            dataready_r <= 1'b0;
          end else begin
            dataready_r <= dataready_r;
          end
          // Leaving ACK only on request low means one request delivers
          // exactly one word.
          if (req_s) begin
            ack_r <= 1'b1;
          end else begin
            ack_r   <= 1'b0;
            state_r <= IDLE;
          end
        end
        default: begin
          ack_r   <= 1'b0;
          stall_r <= 1'b0;
          state_r <= IDLE;
        end
      endcase
    end
  end

endmodule
